axi4lite_req_arbiter: RTL
=========================

# axi4lite_req_arbiter

Round-robin arbiter and transaction sequencer in front of the AXI4-Lite master. It shares the master between `NUM_REQ` requesters and issues one transaction at a time on the master's external request interface. It decides completion by snooping the master's AXI4-Lite handshakes and returns read data or an error to the winning requester.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `data_width`, 32: data width; matches the master.
- `address_width`, 6: address width; matches the master.
- `TIMEOUT_CYCLES`, 256: timeout limit in cycles; used only with `AXIL_ARB_TIMEOUT_EN`.

Ports:
- `ACLK`  in  1  clock.
- `ARESET_N`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*address_width  packed addresses; requester i at [i*address_width +: address_width].
- `req_wdata`  in  NUM_REQ*data_width  packed write data.
- `req_ready`  out  NUM_REQ  one-hot acceptance, combinational.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `rsp_err`  out  1  error flag, valid with `rsp_valid`.
- `rsp_rdata`  out  data_width  read data, valid with `rsp_valid`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current owner.
- `write_request`, `read_request`  out  1  drive the master's request inputs.
- `ext_waddr`, `ext_raddr`  out  address_width  drive the master's address inputs.
- `ext_wdata`  out  data_width  drives the master's write data input.
- `ext_rdata`  in  data_width  read data from the master.
- `AWVALID`, `AWREADY`, `ARVALID`, `ARREADY`, `BVALID`, `BREADY`, `RVALID`, `RREADY`  in  1  snooped from the AXI4-Lite bus.
- `BRESP`  in  2  snooped from the AXI4-Lite bus.

## Operation
FSM states: IDLE, ISSUE, WAIT_RSP, CAPTURE, RESP.
- IDLE:
  - Pick the winner by round-robin: the first set `req_valid` at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[winner]` = 1 combinationally in that cycle. Winner index, direction, address and wdata are latched at that edge.
  - Go to ISSUE.
- ISSUE:
  - `write_request` or `read_request` = 1, matching the latched direction.
  - `ext_waddr`/`ext_wdata` (write) or `ext_raddr` (read) = latched values. The unused address output is 0.
  - Stay until `AWVALID&AWREADY` (write) or `ARVALID&ARREADY` (read). At that edge, drop the request and go to WAIT_RSP.
  - Dropping the request prevents the master from re-issuing.
- WAIT_RSP:
  - Write: on `BVALID&BREADY`, latch `rsp_err = (BRESP != 0)` and go to RESP.
  - Read: on `RVALID&RREADY`, go to CAPTURE.
- CAPTURE: the master's `ext_rdata` lags the R handshake by one cycle, so latch `rsp_rdata <= ext_rdata` here, set `rsp_err` = 0, go to RESP.
- RESP:
  - `rsp_valid[grant]` = 1 for exactly one cycle.
  - `rr_ptr <= (grant+1) mod NUM_REQ`.
  - Go to IDLE. `rsp_rdata` holds its value until the next RESP.
- Requester rules:
  - Hold `req_valid` and its payload stable until `req_ready`.
  - Dropping `req_valid` before `req_ready` is a protocol violation. It is flagged by bench assertion.
  - A requester may assert `req_valid` again in the cycle after its own `rsp_valid`.
- Simultaneous events:
  - No grant is made outside IDLE.
  - When the address handshake and the response handshake occur in the same cycle, ISSUE goes straight to CAPTURE (read) or RESP (write).
- Reset mid-operation: the FSM returns to IDLE and the in-flight transaction is abandoned with no `rsp_valid`.
- Reset values: all outputs = 0, `rr_ptr` = 0, `grant_id` = 0.

## Timing
- Grant to `write_request`/`read_request` high: 1 cycle.
- Master output registers add 2 cycles before `AWVALID`/`ARVALID`.
- `rsp_valid` timing:
  - Write: 1 cycle after the B handshake.
  - Read: 2 cycles after the R handshake.
- Minimum gap between back-to-back grants: 1 IDLE cycle.
- `req_ready` is combinational from `req_valid` and `rr_ptr`. All other outputs are registered.

## Configuration
- `AXIL_ARB_TIMEOUT_EN` defined:
  - A counter, width $clog2(TIMEOUT_CYCLES+1), clears on entering ISSUE and increments in ISSUE and WAIT_RSP.
  - When the count reaches TIMEOUT_CYCLES:
    - drop the request outputs;
    - set `rsp_err` = 1 and `rsp_rdata` = 0;
    - go to RESP.
  - A handshake arriving in the same cycle as the timeout wins over the timeout.
- Not defined: no counter; the FSM waits indefinitely in ISSUE and WAIT_RSP.

## Test plan
- Single write: req0 writes addr 0x04, data 0xDEADBEEF; slave returns BRESP=0. Expected: one AW beat at 0x04, `rsp_valid[0]` for one cycle, `rsp_err`=0, `write_request` low after the AW handshake.
- Single read: req2 reads addr 0x10; slave returns RDATA=0x12345678. Expected: `rsp_rdata`=0x12345678 with `rsp_valid[2]`, exactly 2 cycles after the R handshake.
- Fairness: all four requesters hold reads from reset. Expected: grant order 0,1,2,3,0; no requester granted twice before the others are served.
- Slave error: write with BRESP=2'b10. Expected: `rsp_err`=1 with `rsp_valid`; next grant proceeds normally.
- Timeout (macro on, TIMEOUT_CYCLES=16): AWREADY never asserted. Expected: `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0 exactly 16 cycles after entering ISSUE. With the macro off: `busy` stays high.
- Reset: assert `ARESET_N`=0 in WAIT_RSP. Expected: all outputs 0 immediately, no `rsp_valid`, first grant after reset goes to requester 0.

Source files
------------

// File: rtl/axi4lite_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_req_arbiter
// Summary  : Round-robin arbiter that shares one AXI4-Lite master between
//            NUM_REQ requesters, one transaction at a time. Optional
//            stall timeout is enabled by defining AXIL_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module axi4lite_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int data_width     = 32,
  parameter int address_width  = 6,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                               ACLK,
  input  logic                               ARESET_N,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*address_width-1:0]   req_addr,
  input  logic [NUM_REQ*data_width-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic                               rsp_err,
  output logic [data_width-1:0]              rsp_rdata,
  output logic                               busy,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic                               write_request,
  output logic                               read_request,
  output logic [address_width-1:0]           ext_waddr,
  output logic [address_width-1:0]           ext_raddr,
  output logic [data_width-1:0]              ext_wdata,
  input  logic [data_width-1:0]              ext_rdata,
  input  logic                               AWVALID,
  input  logic                               AWREADY,
  input  logic                               ARVALID,
  input  logic                               ARREADY,
  input  logic                               BVALID,
  input  logic                               BREADY,
  input  logic                               RVALID,
  input  logic                               RREADY,
  input  logic [1:0]                         BRESP
);

  localparam int c_GRANT_W = $clog2(NUM_REQ);
  localparam int c_SUM_W   = c_GRANT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_CAPTURE  = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t                 r_state;
  logic [c_GRANT_W-1:0]   r_rr_ptr;
  logic [c_GRANT_W-1:0]   r_grant;
  logic                   r_write;

  logic                   w_win_any;
  logic [c_GRANT_W-1:0]   w_win_idx;
  logic [c_SUM_W-1:0]     w_cand;
  logic [address_width-1:0] w_sel_addr;
  logic [data_width-1:0]  w_sel_wdata;
  logic                   w_sel_write;
  logic                   w_addr_hs;
  logic                   w_rsp_hs;
  logic                   w_tmo;

  // First pending requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_win_any = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + c_SUM_W'(i);
      if (w_cand >= c_SUM_W'(NUM_REQ))
        w_cand = w_cand - c_SUM_W'(NUM_REQ);
      if (!w_win_any && req_valid[w_cand[c_GRANT_W-1:0]]) begin
        w_win_any = 1'b1;
        w_win_idx = w_cand[c_GRANT_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == c_GRANT_W'(i)) begin
        w_sel_addr  = req_addr[i*address_width +: address_width];
        w_sel_wdata = req_wdata[i*data_width +: data_width];
        w_sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (ARESET_N && (r_state == S_IDLE) && w_win_any)
      req_ready[w_win_idx] = 1'b1;
  end

  assign w_addr_hs = r_write ? (AWVALID & AWREADY) : (ARVALID & ARREADY);
  assign w_rsp_hs  = r_write ? (BVALID & BREADY)   : (RVALID & RREADY);
  assign grant_id  = r_grant;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_TMO_W-1:0] r_tmo_cnt;

  // Fires on the edge where the count would reach TIMEOUT_CYCLES.
  assign w_tmo = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N)
      r_tmo_cnt <= '0;
    else if (r_state == S_ISSUE || r_state == S_WAIT_RSP)
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    else
      r_tmo_cnt <= '0;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_write       <= 1'b0;
      write_request <= 1'b0;
      read_request  <= 1'b0;
      ext_waddr     <= '0;
      ext_raddr     <= '0;
      ext_wdata     <= '0;
      rsp_valid     <= '0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      busy          <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_win_any) begin
            r_state       <= S_ISSUE;
            busy          <= 1'b1;
            r_grant       <= w_win_idx;
            r_write       <= w_sel_write;
            write_request <= w_sel_write;
            read_request  <= ~w_sel_write;
            ext_waddr     <= w_sel_write ? w_sel_addr : '0;
            ext_raddr     <= w_sel_write ? '0 : w_sel_addr;
            ext_wdata     <= w_sel_write ? w_sel_wdata : '0;
          end
        end
        S_ISSUE: begin
          if (w_addr_hs) begin
            // Dropping the request here keeps the master from re-issuing.
            write_request <= 1'b0;
            read_request  <= 1'b0;
            if (w_rsp_hs && r_write) begin
              rsp_err            <= (BRESP != 2'b00);
              rsp_valid[r_grant] <= 1'b1;
              r_state            <= S_RESP;
            end else if (w_rsp_hs) begin
              r_state <= S_CAPTURE;
            end else begin
              r_state <= S_WAIT_RSP;
            end
          end else if (w_tmo) begin
            write_request      <= 1'b0;
            read_request       <= 1'b0;
            rsp_err            <= 1'b1;
            rsp_rdata          <= '0;
            rsp_valid[r_grant] <= 1'b1;
            r_state            <= S_RESP;
          end
        end
        S_WAIT_RSP: begin
          if (w_rsp_hs && r_write) begin
            rsp_err            <= (BRESP != 2'b00);
            rsp_valid[r_grant] <= 1'b1;
            r_state            <= S_RESP;
          end else if (w_rsp_hs) begin
            r_state <= S_CAPTURE;
          end else if (w_tmo) begin
            rsp_err            <= 1'b1;
            rsp_rdata          <= '0;
            rsp_valid[r_grant] <= 1'b1;
            r_state            <= S_RESP;
          end
        end
        S_CAPTURE: begin
          // The master presents read data one cycle after the R handshake.
          rsp_rdata          <= ext_rdata;
          rsp_err            <= 1'b0;
          rsp_valid[r_grant] <= 1'b1;
          r_state            <= S_RESP;
        end
        S_RESP: begin
          r_rr_ptr <= (r_grant == c_GRANT_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
